// File: rtl/can_apb_bridge_if.sv
// APB slave and MC-side bus bundle for the CAN register bridge.
// Bridge takes the slave view; the environment takes the master view.
interface can_apb_bridge_if;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [7:0]  i_paddr;
  logic [31:0] i_pwdata;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic        o_pslverr;
  logic        o_cs;
  logic        o_r_neg_w;
  logic [5:0]  o_addr;
  logic [31:0] o_bus_data;
  logic [31:0] i_reg_data;
  logic        i_ack;
  logic        i_error;

  modport slave (
    input  i_psel, i_penable, i_pwrite,
    input  i_paddr, i_pwdata,
    output o_prdata, o_pready, o_pslverr,
    output o_cs, o_r_neg_w, o_addr, o_bus_data,
    input  i_reg_data, i_ack, i_error
  );

  modport master (
    output i_psel, i_penable, i_pwrite,
    output i_paddr, i_pwdata,
    input  o_prdata, o_pready, o_pslverr,
    input  o_cs, o_r_neg_w, o_addr, o_bus_data,
    output i_reg_data, i_ack, i_error
  );
endinterface

// File: rtl/can_apb_bridge.sv
// APB slave to CAN MC register-port bridge.
// Three-state FSM with ack timeout; every output is registered.
module can_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              i_sys_clk,
  input logic              i_reset_n,
  can_apb_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        rnw_q, rnw_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic setup;
  logic legal;

  assign setup = bus.i_psel & ~bus.i_penable;
  assign legal = (bus.i_paddr[1:0] == 2'b00) &&
                 (bus.i_paddr[7:2] <= 6'd30);

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (legal) begin
            state_d = ACCESS;
            cnt_d   = '0;
            cs_d    = 1'b1;
            rnw_d   = ~bus.i_pwrite;
            addr_d  = bus.i_paddr[7:2];
            data_d  = bus.i_pwrite ? bus.i_pwdata : '0;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end
        end
      end
      ACCESS: begin
        // ack wins over a timeout landing on the same cycle
        if (bus.i_ack) begin
          state_d   = RESP;
          cs_d      = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = bus.i_error;
          prdata_d  = rnw_q ? bus.i_reg_data : '0;
        end else if (cnt_q == LAST) begin
          state_d   = RESP;
          cs_d      = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  assign bus.o_cs       = cs_q;
  assign bus.o_r_neg_w  = rnw_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_bus_data = data_q;
  assign bus.o_prdata   = prdata_q;
  assign bus.o_pready   = pready_q;
  assign bus.o_pslverr  = pslverr_q;

endmodule

// File: tb/tb_can_apb_bridge.sv
// Bench for can_apb_bridge: directed cases plus random transfers
// checked against a per-transfer outcome model.
module tb_can_apb_bridge;

  localparam int T = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_prdata;

  can_apb_bridge_if bus ();

  can_apb_bridge #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_sys_clk (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    bus.i_ack     = 1'b0;
    bus.i_error   = 1'b0;
  endtask

  // One APB transfer; ack_at is the 1-based o_cs cycle carrying i_ack
  // (0 or beyond T means the MC never answers in time).
  task automatic xfer(input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int ack_at, input bit err);
    bit          legal;
    bit          tmo;
    int          n;
    int          cyc;
    int          cs_cnt;
    bit          seen;
    logic [31:0] ep;
    logic [31:0] ee;
    legal = (a % 4 == 0) && (a / 4 <= 30);
    tmo   = !(ack_at >= 1 && ack_at <= T);
    if (!legal) begin
      n  = 0;
      ee = 1;
      ep = 0;
    end else begin
      n  = tmo ? T : ack_at;
      ee = tmo ? 1 : 32'(err);
      ep = (tmo || wr) ? 0 : rd;
    end
    @(negedge clk);
    chk("idle_pready", 32'(bus.o_pready), 0);
    chk("idle_pslverr", 32'(bus.o_pslverr), 0);
    chk("prdata_hold", bus.o_prdata, last_prdata);
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = wr;
    bus.i_paddr   = a;
    bus.i_pwdata  = wd;
    bus.i_ack     = 1'($urandom);
    bus.i_error   = 1'($urandom);
    bus.i_reg_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.i_penable = 1'b1;
    cyc    = 0;
    cs_cnt = 0;
    seen   = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      cyc++;
      if (bus.o_cs) begin
        cs_cnt++;
        chk("cs_addr", 32'(bus.o_addr), 32'(a / 4));
        chk("cs_rnw", 32'(bus.o_r_neg_w), 32'(!wr));
        chk("cs_data", bus.o_bus_data, wr ? wd : 32'h0);
        bus.i_ack      = (cs_cnt == ack_at);
        bus.i_error    = err;
        bus.i_reg_data = rd;
        if ($urandom_range(0, 3) == 0) begin
          bus.i_psel    = 1'($urandom);
          bus.i_penable = 1'b0;
          bus.i_paddr   = 8'($urandom);
        end
      end else if (bus.o_pready) begin
        seen = 1;
        chk("resp_pslverr", 32'(bus.o_pslverr), ee);
        chk("resp_prdata", bus.o_prdata, ep);
        chk("cs_cycles", 32'(cs_cnt), 32'(n));
        chk("latency", 32'(cyc), 32'(n + 1));
        bus.i_psel    = 1'($urandom);
        bus.i_penable = 1'b0;
        bus.i_pwrite  = 1'($urandom);
        bus.i_paddr   = 8'($urandom);
        bus.i_ack     = 1'($urandom);
        bus.i_error   = 1'($urandom);
      end else begin
        bus.i_ack   = 1'($urandom);
        bus.i_error = 1'($urandom);
      end
    end
    if (!seen) chk("pready_seen", 0, 1);
    last_prdata = ep;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cs"}, 32'(bus.o_cs), 0);
    chk({tag, "_rnw"}, 32'(bus.o_r_neg_w), 0);
    chk({tag, "_addr"}, 32'(bus.o_addr), 0);
    chk({tag, "_data"}, bus.o_bus_data, 0);
    chk({tag, "_prdata"}, bus.o_prdata, 0);
    chk({tag, "_pready"}, 32'(bus.o_pready), 0);
    chk({tag, "_pslverr"}, 32'(bus.o_pslverr), 0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    last_prdata = 0;
    rst_n       = 1'b0;
    quiet();
    bus.i_pwrite   = 1'b0;
    bus.i_paddr    = 8'h0;
    bus.i_pwdata   = 32'h0;
    bus.i_reg_data = 32'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    xfer(1, 8'h08, 32'hDEADBEEF, 32'h0, 3, 0);
    xfer(0, 8'h78, 32'h0, 32'h12345678, 1, 0);
    xfer(0, 8'h7C, 32'h0, 32'hAAAA5555, 1, 0);
    xfer(0, 8'h05, 32'h0, 32'hAAAA5555, 1, 0);
    xfer(0, 8'h10, 32'h0, 32'hCAFEF00D, 0, 0);
    xfer(0, 8'h14, 32'h0, 32'h0BADC0DE, T, 1);
    xfer(1, 8'h00, 32'h11223344, 32'h0, T + 1, 0);
    xfer(0, 8'h20, 32'h0, 32'h55667788, 2, 0);
    xfer(0, 8'h24, 32'h0, 32'h99AABBCC, 1, 1);

    @(negedge clk);
    quiet();
    bus.i_psel    = 1'b1;
    bus.i_pwrite  = 1'b1;
    bus.i_paddr   = 8'h0C;
    bus.i_pwdata  = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    bus.i_penable = 1'b1;
    chk("pre_rst_cs", 32'(bus.o_cs), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    quiet();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_pready", 32'(bus.o_pready), 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    last_prdata = 0;
    xfer(1, 8'h18, 32'h0F0F0F0F, 32'h0, 2, 0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      if ($urandom_range(0, 1) == 1)
        a = {6'($urandom_range(0, 31)), 2'b00};
      else
        a = 8'($urandom);
      xfer(1'($urandom), a, $urandom, $urandom,
           $urandom_range(0, T + 2), 1'($urandom));
    end

    @(negedge clk);
    quiet();
    repeat (2) @(negedge clk);
    chk("end_pready", 32'(bus.o_pready), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
